// File: rtl/complex_div_pkg.sv
// Shared types and sizing for the sequential complex divider.
// Width helpers let the RTL size itself from WIDTH; the CDIV_* constants describe the default W=16 build.
package complex_div_pkg;

    typedef enum logic [1:0] {
        CDIV_IDLE,
        CDIV_MUL,
        CDIV_DIV,
        CDIV_DONE
    } cdiv_state_t;

    function automatic int cdiv_num_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int cdiv_den_w(input int w);
        return 2 * w;
    endfunction

    function automatic int cdiv_iters(input int w);
        return 2 * w + 1;
    endfunction

    localparam int CDIV_W        = 16;
    localparam int CDIV_NUM_W    = cdiv_num_w(CDIV_W);
    localparam int CDIV_DEN_W    = cdiv_den_w(CDIV_W);
    localparam int CDIV_ITERS    = cdiv_iters(CDIV_W);
    localparam int CDIV_LAT_NORM = 2 * CDIV_W + 2;
    localparam int CDIV_LAT_DZ   = 2;
    localparam int CDIV_PERIOD   = 2 * CDIV_W + 4;

endpackage

// File: rtl/complex_num.sv
// Complex number bundle shared across the complex datapath stages.
interface complex_num #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] riyal;
    logic signed [WIDTH-1:0] imag;

    modport IN  (input  riyal, input  imag);
    modport OUT (output riyal, output imag);
endinterface

// File: rtl/complex_div_seq_udiv.sv
// Unsigned restoring divider producing one quotient bit per cycle, MSB first.
// quotient/done are valid combinationally during the final step so the caller can capture on that edge.
module seq_udiv
    import complex_div_pkg::*;
#(
    parameter int NW = cdiv_num_w(16),
    parameter int DW = cdiv_den_w(16)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [NW-1:0] quotient,
    output logic          done
);
    localparam int CW = $clog2(NW);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rem;
    logic [NW-1:0] acc;
    logic [DW-1:0] dsr;
    logic [DW:0]   trial;
    logic          fits;
    logic [DW-1:0] rem_nxt;

    // The dividend register doubles as the quotient shift register.
    assign trial    = {rem, acc[NW-1]};
    assign fits     = trial >= {1'b0, dsr};
    assign rem_nxt  = DW'(fits ? trial - {1'b0, dsr} : trial);
    assign quotient = {acc[NW-2:0], fits};
    assign done     = busy && (cnt == CW'(NW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rem <= '0;
            acc <= dividend;
            dsr <= divisor;
        end else if (busy) begin
            rem <= rem_nxt;
            acc <= quotient;
        end
    end
endmodule

// File: rtl/complex_div.sv
// Sequential complex divider: (a+bj)/(c+dj), truncated toward zero, valid/ready on both sides.
// Define COMPLEX_DIV_SAT_EN to clamp out-of-range components instead of wrapping them.
module complex_div
    import complex_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    complex_num.IN         num,
    complex_num.IN         den,
    output logic           out_valid,
    input  logic           out_ready,
    complex_num.OUT        quo,
    output logic           div_zero,
    output logic           ovf
);
    localparam int NW = cdiv_num_w(WIDTH);
    localparam int DW = cdiv_den_w(WIDTH);
    localparam logic [NW-1:0] POS_LIM = NW'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic [NW-1:0] NEG_LIM = NW'(64'd1 << (WIDTH - 1));

    cdiv_state_t state, state_nxt;

    logic signed [WIDTH-1:0] a_p0, b_p0, c_p0, d_p0;
    logic signed [NW-1:0]    nr, ni;
    logic signed [DW-1:0]    cc, dsq;
    logic [DW-1:0]           dd;
    logic [NW-1:0]           nr_mag, ni_mag;
    logic                    neg_re_p1, neg_im_p1, dz_p1;
    logic [NW-1:0]           q_re, q_im;
    logic                    done_re, done_im, div_done, start;
    logic signed [WIDTH-1:0] quo_re, quo_im;

    function automatic logic range_ovf(input logic [NW-1:0] mag, input logic neg);
        return neg ? (mag > NEG_LIM) : (mag > POS_LIM);
    endfunction

    function automatic logic signed [WIDTH-1:0] fit(input logic [NW-1:0] mag, input logic neg);
        logic [WIDTH-1:0] low;
        low = mag[WIDTH-1:0];
`ifdef COMPLEX_DIV_SAT_EN
        if (range_ovf(mag, neg))
            return neg ? $signed({1'b1, {(WIDTH-1){1'b0}}}) : $signed({1'b0, {(WIDTH-1){1'b1}}});
`endif
        return neg ? $signed(-low) : $signed(low);
    endfunction

    // Stage p0 -> p1: products from the captured operands, evaluated during MUL.
    assign nr     = NW'(a_p0) * NW'(c_p0) + NW'(b_p0) * NW'(d_p0);
    assign ni     = NW'(b_p0) * NW'(c_p0) - NW'(a_p0) * NW'(d_p0);
    assign cc     = DW'(c_p0) * DW'(c_p0);
    assign dsq    = DW'(d_p0) * DW'(d_p0);
    assign dd     = $unsigned(cc + dsq);
    assign nr_mag = nr[NW-1] ? $unsigned(-nr) : $unsigned(nr);
    assign ni_mag = ni[NW-1] ? $unsigned(-ni) : $unsigned(ni);
    assign start  = (state == CDIV_MUL) && (dd != '0);

    seq_udiv #(.NW(NW), .DW(DW)) u_div_re (
        .clk(clk), .rst(rst), .start(start), .dividend(nr_mag), .divisor(dd),
        .quotient(q_re), .done(done_re)
    );

    seq_udiv #(.NW(NW), .DW(DW)) u_div_im (
        .clk(clk), .rst(rst), .start(start), .dividend(ni_mag), .divisor(dd),
        .quotient(q_im), .done(done_im)
    );

    assign div_done  = done_re && done_im;
    assign in_ready  = (state == CDIV_IDLE) && !rst;
    assign quo.riyal = quo_re;
    assign quo.imag  = quo_im;

    always_comb begin
        state_nxt = state;
        case (state)
            CDIV_IDLE: if (in_valid && in_ready) state_nxt = CDIV_MUL;
            CDIV_MUL:  state_nxt = CDIV_DIV;
            // A zero divisor spends one DIV cycle with the dividers idle, then reports.
            CDIV_DIV:  if (dz_p1 || div_done) state_nxt = CDIV_DONE;
            CDIV_DONE: if (out_ready) state_nxt = CDIV_IDLE;
            default:   state_nxt = CDIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == CDIV_IDLE && in_valid && in_ready) begin
            a_p0 <= num.riyal;
            b_p0 <= num.imag;
            c_p0 <= den.riyal;
            d_p0 <= den.imag;
        end
        if (state == CDIV_MUL) begin
            neg_re_p1 <= nr[NW-1];
            neg_im_p1 <= ni[NW-1];
            dz_p1     <= (dd == '0);
        end
    end

    // Stage p1 -> output: sign restore and range handling on the final divider step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CDIV_IDLE;
            out_valid <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
            quo_re    <= '0;
            quo_im    <= '0;
        end else begin
            state <= state_nxt;
            if (state == CDIV_DIV && dz_p1) begin
                out_valid <= 1'b1;
                div_zero  <= 1'b1;
                ovf       <= 1'b0;
                quo_re    <= '0;
                quo_im    <= '0;
            end else if (state == CDIV_DIV && div_done) begin
                out_valid <= 1'b1;
                div_zero  <= 1'b0;
                ovf       <= range_ovf(q_re, neg_re_p1) || range_ovf(q_im, neg_im_p1);
                quo_re    <= fit(q_re, neg_re_p1);
                quo_im    <= fit(q_im, neg_im_p1);
            end else if (state == CDIV_DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
